// File: rtl/cdc_hs_tx_if.sv
// Handshake bundle for the source end of a toggle req/ack clock crossing.
// Carries the payload valid/ready port, the held payload and req toward the
// far domain, the asynchronous ack back, and the done/err status outputs.
// The slave modport is the transmitter; the master modport is its user.
interface cdc_hs_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  req_o;
    logic                  ack_i;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  valid_i,
        input  dat_i,
        input  ack_i,
        output ready_o,
        output dat_o,
        output req_o,
        output done_o,
        output err_o
    );

    modport master (
        output valid_i,
        output dat_i,
        output ack_i,
        input  ready_o,
        input  dat_o,
        input  req_o,
        input  done_o,
        input  err_o
    );
endinterface

// File: rtl/cdc_hs_tx.sv
// Source end of a two-phase (toggle) req/ack CDC handshake; dat_o is held while req_o toggles.
// Latency: accept -> req_o/dat_o 1 cycle; ack_i toggle -> done_o STAGE cycles (+0..1 sampling).
// Backpressure: ready_o is low from accept until the cycle done_o pulses (back-to-back allowed).
//
// Ports: clk_i/rst_i (sync, active-high reset) plus interface hs (slave modport):
//   valid_i/ready_o/dat_i  payload input port
//   dat_o/req_o            registered payload and toggle request toward the far domain
//   ack_i                  toggle ack from the far domain (asynchronous, synchronized here)
//   done_o                 1-cycle completion pulse
//   err_o                  sticky ack timeout flag
// Optional feature: define CDC_HS_TX_TIMEOUT_EN to build the WAIT_ACK timeout
// counter; without it err_o is constant 0 and TIMEOUT is unused.
module cdc_hs_tx #(
    parameter int STAGE      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cdc_hs_tx_if.slave hs
);
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_req;
    logic                  r_done;
    logic [STAGE-1:0]      r_ack_sync;
    logic                  w_ack_s;
    logic                  w_accept;

    assign w_ack_s    = r_ack_sync[STAGE-1];
    assign hs.ready_o = (r_state == ST_IDLE) & ~rst_i;
    assign w_accept   = hs.valid_i & hs.ready_o;

    assign hs.dat_o  = r_dat;
    assign hs.req_o  = r_req;
    assign hs.done_o = r_done;

    // ack_i synchronizer; the last stage is the only one the FSM looks at.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[STAGE-2:0], hs.ack_i};
        end
    end

    // Completion is judged by phase equality rather than edge detection, so a
    // transfer finishes whenever the synchronized ack has caught up with req,
    // and an ack that moves while IDLE has no effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_dat   <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dat   <= hs.dat_i;
                        r_req   <= ~r_req;
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_ack_s == r_req) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Counts WAIT_ACK cycles since the accept; err_o rises on the edge the
    // count reaches TIMEOUT. The transfer itself is left running.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_cnt <= '0;
            end
        end else begin
            if (r_cnt != CW'(TIMEOUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CW'(TIMEOUT - 1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hs.err_o = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign hs.err_o         = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: directed scenarios plus randomized transfers, with the
// far end of the crossing modelled as a delayed ack toggle.
// Expected req phase, payload and completion count come from a transaction model.
module tb_cdc_hs_tx;
    localparam int DW  = 8;
    localparam int STG = 2;
`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    cdc_hs_tx_if #(.DATA_WIDTH(DW)) hs ();

    cdc_hs_tx #(.STAGE(STG), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hs    (hs)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: req phase is the parity of accepted transfers
    // since reset; every accepted transfer that is acked completes exactly once.
    bit      m_phase     = 1'b0;
    int      m_completed = 0;
    int      done_seen   = 0;

    always @(negedge clk_i) begin
        if (hs.done_o === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_i      = 1'b1;
        hs.valid_i = 1'b0;
        hs.ack_i   = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("rst_req",   hs.req_o,   0);
            check("rst_dat",   hs.dat_o,   0);
            check("rst_done",  hs.done_o,  0);
            check("rst_err",   hs.err_o,   0);
            check("rst_ready", hs.ready_o, 0);
        end
        rst_i   = 1'b0;
        m_phase = 1'b0;
        #1;
        check("post_rst_ready", hs.ready_o, 1);
    endtask

    // Wait for done_o after the far end has toggled ack; returns ticks taken.
    task automatic wait_done(input logic [7:0] d, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (hs.done_o === 1'b1) got = 1'b1;
        end
        hs.valid_i = 1'b0;
        check("done_seen",  got, 1);
        check("done_ready", hs.ready_o, 1);
        check("done_dat",   hs.dat_o, d);
        check("done_req",   hs.req_o, m_phase);
        m_completed++;
    endtask

    // One full transfer: accept, hold for ack_dly cycles with noise on the
    // input port, far end toggles ack, then completion.
    task automatic xfer(input logic [7:0] d, input int ack_dly, input bit busy_ff);
        int lat;
        check("idle_ready", hs.ready_o, 1);
        hs.valid_i = 1'b1;
        hs.dat_i   = d;
        tick();
        m_phase = ~m_phase;
        check("acc_dat",   hs.dat_o,   d);
        check("acc_req",   hs.req_o,   m_phase);
        check("acc_ready", hs.ready_o, 0);
        for (int i = 0; i < ack_dly; i++) begin
            if (busy_ff) begin
                hs.valid_i = 1'b1;
                hs.dat_i   = 8'hFF;
            end else begin
                hs.valid_i = 1'($urandom_range(0, 1));
                hs.dat_i   = 8'($urandom);
            end
            tick();
            check("hold_dat",   hs.dat_o,   d);
            check("hold_req",   hs.req_o,   m_phase);
            check("hold_ready", hs.ready_o, 0);
            check("hold_done",  hs.done_o,  0);
            check("hold_err",   hs.err_o,   0);
        end
        hs.ack_i = m_phase;
        wait_done(d, lat);
        check("ack_lat_2to3", (lat >= 2 && lat <= 3), 1);
        tick();
        check("done_pulse", hs.done_o, 0);
    endtask

    initial begin
        int lat;
        int n;
        int base;
        rst_i      = 1'b1;
        hs.valid_i = 1'b0;
        hs.dat_i   = '0;
        hs.ack_i   = 1'b0;

        // 1: reset held 3 cycles
        do_reset(3);

        // 2: single transfer, ack toggled 4 cycles after accept
        xfer(8'hA5, 4, 1'b0);
        check("t2_done_cnt", done_seen, m_completed);

        // 3: back-to-back with far end looped back
        do_reset(1);
        base       = done_seen;
        hs.valid_i = 1'b1;
        hs.dat_i   = 8'h01;
        tick();
        m_phase = ~m_phase;
        check("b2b_req1", hs.req_o, 1);
        check("b2b_dat1", hs.dat_o, 8'h01);
        hs.dat_i = 8'h02;
        hs.ack_i = m_phase;
        n = 0;
        while (hs.done_o !== 1'b1 && n < 10) begin
            tick();
            n++;
            check("b2b_hold1", hs.dat_o, 8'h01);
        end
        check("b2b_first_done", hs.done_o, 1);
        check("b2b_ready_at_done", hs.ready_o, 1);
        tick();
        m_phase = ~m_phase;
        m_completed++;
        hs.valid_i = 1'b0;
        check("b2b_dat2", hs.dat_o, 8'h02);
        check("b2b_req2", hs.req_o, 0);
        check("b2b_no_done", hs.done_o, 0);
        hs.ack_i = m_phase;
        wait_done(8'h02, lat);
        tick();
        check("b2b_two_dones", done_seen - base, 2);

        // 4: busy hold with FF offered, then even-count ack pulse while IDLE
        xfer(8'h3C, 5, 1'b1);
        base     = done_seen;
        hs.ack_i = ~m_phase;
        repeat (3) tick();
        hs.ack_i = m_phase;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("spur_done",  hs.done_o,  0);
            check("spur_ready", hs.ready_o, 1);
            check("spur_dat",   hs.dat_o,   8'h3C);
            check("spur_req",   hs.req_o,   m_phase);
        end
        check("spur_done_cnt", done_seen - base, 0);

        // 5: reset 2 cycles after accept
        base       = done_seen;
        hs.valid_i = 1'b1;
        hs.dat_i   = 8'h5A;
        tick();
        hs.valid_i = 1'b0;
        tick();
        tick();
        do_reset(2);
        repeat (4) tick();
        check("abort_no_done", done_seen - base, 0);
        xfer(8'h77, 3, 1'b0);

        // Randomized transfers with idle gaps
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) begin
                tick();
                check("gap_ready", hs.ready_o, 1);
                check("gap_done",  hs.done_o,  0);
            end
            xfer(8'($urandom), $urandom_range(0, 8), 1'b0);
        end
        tick();
        check("total_dones", done_seen, m_completed);

        // 6: timeout behaviour
`ifdef CDC_HS_TX_TIMEOUT_EN
        hs.valid_i = 1'b1;
        hs.dat_i   = 8'hC3;
        tick();
        hs.valid_i = 1'b0;
        m_phase    = ~m_phase;
        n = 0;
        while (hs.err_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, TMO);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tmo_sticky", hs.err_o, 1);
            check("tmo_no_done", hs.done_o, 0);
        end
        hs.ack_i = m_phase;
        wait_done(8'hC3, lat);
        tick();
        check("tmo_err_after_done", hs.err_o, 1);
        check("tmo_done_cnt", done_seen, m_completed);
`else
        check("no_tmo_err", hs.err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
